lsu_mem_stage: RTL and testbench

- Memory-access stage directly downstream of the RV32I ALU.
- Takes the ALU result as the effective address, plus store data and funct3, from the execute stage.
- Runs one data-bus transaction per request over a req/ack handshake. Load data is aligned and sign/zero-extended for writeback.
- One request in flight at a time; the pipeline stalls through req_ready.

---
 rtl/lsu_mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - RV32I memory-access stage: one bus transaction per request, load align/extend
//
// Purpose:
//   Sits between the ALU and writeback. It accepts one memory op at a time and
//   runs a single req/ack bus transaction for it. The result is held on resp_*
//   until writeback accepts it.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   execute-stage handshake (req_ready high only in IDLE)
//   req_we, req_funct3    store/load select and access size/sign
//   req_addr, req_wdata   effective address and store data
//   req_rd                destination register, passed through to resp_rd
//   mem_req/mem_ack       data-bus handshake (mem_req held until ack)
//   mem_we, mem_addr      bus write select and word-aligned address
//   mem_be, mem_wdata     byte enables and lane-replicated store data
//   mem_rdata             read word, valid with mem_ack on loads
//   resp_valid/ready      writeback handshake
//   resp_rdata, resp_rd   extended load data (0 for stores), captured rd
//   resp_err              misaligned-access trap flag
//
// Build option:
//   MISALIGN_TRAP_EN  when defined, misaligned H/W accesses skip the bus and
//                     return resp_err=1 with the address as the trap value.
//                     When undefined, resp_err is 0 and misaligned low bits are ignored.

module lsu_mem_stage #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] DEADBEEF_FILL = 32'hdeadbeef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [4:0]       resp_rd,
  output logic             resp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       cap_funct3;
  logic [1:0]       cap_off;

  logic             is_b, is_h, is_w, legal;
  logic [3:0]       be_next;
  logic [WIDTH-1:0] wdata_next;
  logic [1:0]       ld_off;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_data;

  assign req_ready  = (state == S_IDLE);
  assign mem_req    = (state == S_BUS);
  assign resp_valid = (state == S_DONE);

  // Decode of the incoming request; funct3[2] only selects zero-extension,
  // so unsigned sizes are illegal for stores.
  always_comb begin
    is_b  = (req_funct3[1:0] == 2'b00);
    is_h  = (req_funct3[1:0] == 2'b01);
    is_w  = (req_funct3 == 3'b010);
    legal = is_w | ((is_b | is_h) & (~req_funct3[2] | ~req_we));

    be_next = 4'b0001 << req_addr[1:0];
    if (is_w) begin
      be_next = 4'b1111;
    end else if (is_h) begin
      be_next = 4'b0011 << {req_addr[1], 1'b0};
    end

    wdata_next = req_wdata;
    if (is_b) begin
      wdata_next = {4{req_wdata[7:0]}};
    end else if (is_h) begin
      wdata_next = {2{req_wdata[15:0]}};
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic resp_err_q;

  assign misalign = (is_h & req_addr[0]) | (is_w & (req_addr[1:0] != 2'b00));
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Load extraction uses the captured size and low address bits; the shift
  // amount matches the byte-enable placement so the addressed lane lands in bits 7:0.
  always_comb begin
    ld_off = 2'b00;
    if (cap_funct3[1:0] == 2'b00) begin
      ld_off = cap_off;
    end else if (cap_funct3[1:0] == 2'b01) begin
      ld_off = {cap_off[1], 1'b0};
    end
    shifted = mem_rdata >> {ld_off, 3'b000};

    case (cap_funct3)
      3'b000:  load_data = {{(WIDTH-8){shifted[7]}},   shifted[7:0]};
      3'b001:  load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(WIDTH-8){1'b0}},         shifted[7:0]};
      3'b101:  load_data = {{(WIDTH-16){1'b0}},        shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cap_funct3 <= 3'b000;
      cap_off    <= 2'b00;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_rd    <= 5'd0;
`ifdef MISALIGN_TRAP_EN
      resp_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            resp_rd    <= req_rd;
            cap_funct3 <= req_funct3;
            cap_off    <= req_addr[1:0];
`ifdef MISALIGN_TRAP_EN
            resp_err_q <= 1'b0;
`endif
            if (!legal) begin
              resp_rdata <= DEADBEEF_FILL;
              state      <= S_DONE;
`ifdef MISALIGN_TRAP_EN
            end else if (misalign) begin
              resp_rdata <= req_addr;
              resp_err_q <= 1'b1;
              state      <= S_DONE;
`endif
            end else begin
              mem_we    <= req_we;
              mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              state     <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (mem_ack) begin
            resp_rdata <= mem_we ? '0 : load_data;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - table-driven self-checking bench for lsu_mem_stage

module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          hold;
    logic        bus;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] exp_rdata;
    logic        err;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input int i);
    vec_t v;
    v = vecs[i];
    check({v.name, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = 5'(i + 3);
    step();
    req_valid = 1'b0;
    req_addr  = 32'h0;
    if (v.bus) begin
      check({v.name, " mem_req"},   32'(mem_req),   32'd1);
      check({v.name, " resp_valid early"}, 32'(resp_valid), 32'd0);
      check({v.name, " mem_we"},    32'(mem_we),    32'(v.we));
      check({v.name, " mem_be"},    32'(mem_be),    32'(v.be));
      check({v.name, " mem_addr"},  mem_addr,       v.maddr);
      if (v.we) check({v.name, " mem_wdata"}, mem_wdata, v.mwdata);
      // ack withheld; a new request presented meanwhile must be ignored
      for (int d = 0; d < v.delay; d++) begin
        req_valid = 1'b1;
        req_addr  = 32'hFFFF_FFFC;
        req_funct3 = 3'b010;
        step();
        check({v.name, " mem_req held"},   32'(mem_req),   32'd1);
        check({v.name, " req_ready busy"}, 32'(req_ready), 32'd0);
        check({v.name, " mem_addr stable"}, mem_addr,      v.maddr);
        check({v.name, " mem_be stable"},  32'(mem_be),    32'(v.be));
      end
      req_valid = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      check({v.name, " mem_req dropped"}, 32'(mem_req), 32'd0);
    end else begin
      check({v.name, " no mem_req"}, 32'(mem_req), 32'd0);
    end
    check({v.name, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({v.name, " resp_rdata"}, resp_rdata,      v.exp_rdata);
    check({v.name, " resp_err"},   32'(resp_err),   32'(v.err));
    check({v.name, " resp_rd"},    32'(resp_rd),    32'(i + 3));
    for (int h = 0; h < v.hold; h++) begin
      resp_ready = 1'b0;
      step();
      check({v.name, " resp_valid hold"}, 32'(resp_valid), 32'd1);
      check({v.name, " resp_rdata hold"}, resp_rdata,      v.exp_rdata);
      check({v.name, " req_ready hold"},  32'(req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({v.name, " resp_valid clear"}, 32'(resp_valid), 32'd0);
    check({v.name, " req_ready back"},   32'(req_ready),  32'd1);
  endtask

  initial begin
    //        name    we    f3      addr          wdata         rdata         dly hold bus be       maddr         mwdata        exp_rdata     err
    vecs[0]  = '{"LB",   1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 1'b1, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{"LHU",  1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0001, 0, 0, 1'b1, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_BEEF, 1'b0};
    vecs[2]  = '{"LH",   1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_0001, 1, 0, 1'b1, 4'b1100, 32'h0000_2000, 32'h0,        32'hFFFF_BEEF, 1'b0};
    vecs[3]  = '{"SB",   1'b1, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 5, 0, 1'b1, 4'b0010, 32'h0000_3000, 32'hABAB_ABAB, 32'h0,        1'b0};
`ifdef MISALIGN_TRAP_EN
    vecs[4]  = '{"LWmis",1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'hCAFE_F00D, 0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0000_4002, 1'b1};
`else
    vecs[4]  = '{"LWmis",1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'hCAFE_F00D, 0, 0, 1'b1, 4'b1111, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 1'b0};
`endif
    vecs[5]  = '{"ILL011",1'b0,3'b011, 32'h0000_5000, 32'h0,        32'h0,         0, 3, 1'b0, 4'b0000, 32'h0,        32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{"SH",   1'b1, 3'b001, 32'h0000_5002, 32'hAAAA_1234, 32'h0,         2, 0, 1'b1, 4'b1100, 32'h0000_5000, 32'h1234_1234, 32'h0,        1'b0};
    vecs[7]  = '{"SW",   1'b1, 3'b010, 32'h0000_6000, 32'h0102_0304, 32'h0,         0, 1, 1'b1, 4'b1111, 32'h0000_6000, 32'h0102_0304, 32'h0,        1'b0};
    vecs[8]  = '{"LBU",  1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h1122_9344, 0, 0, 1'b1, 4'b0010, 32'h0000_7000, 32'h0,        32'h0000_0093, 1'b0};
    vecs[9]  = '{"SBU",  1'b1, 3'b100, 32'h0000_7000, 32'h5555_5555, 32'h0,         0, 0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{"LB0",  1'b0, 3'b000, 32'h0000_8000, 32'h0,        32'hFFFF_FF7F, 0, 0, 1'b1, 4'b0001, 32'h0000_8000, 32'h0,        32'h0000_007F, 1'b0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    resp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("reset req_ready",  32'(req_ready),  32'd1);
    check("reset mem_req",    32'(mem_req),    32'd0);
    check("reset mem_be",     32'(mem_be),     32'd0);
    check("reset mem_addr",   mem_addr,        32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata,      32'd0);
    check("reset resp_err",   32'(resp_err),   32'd0);

    for (int i = 0; i < NVEC; i++) run_op(i);

    // reset while in BUS, then a late ack
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_9000;
    req_rd     = 5'd17;
    step();
    req_valid = 1'b0;
    check("rst mid mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    check("rst mid mem_req dropped", 32'(mem_req),    32'd0);
    check("rst mid req_ready",       32'(req_ready),  32'd1);
    check("rst mid mem_we",          32'(mem_we),     32'd0);
    check("rst mid mem_addr",        mem_addr,        32'd0);
    check("rst mid mem_be",          32'(mem_be),     32'd0);
    check("rst mid mem_wdata",       mem_wdata,       32'd0);
    check("rst mid resp_rd",         32'(resp_rd),    32'd0);
    step();
    mem_ack = 1'b0;
    check("late ack resp_valid", 32'(resp_valid), 32'd0);
    check("late ack mem_req",    32'(mem_req),    32'd0);
    check("late ack req_ready",  32'(req_ready),  32'd1);
    check("late ack resp_rdata", resp_rdata,      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
